// File: rtl/if_wr_sched.sv
// Write scheduler: round-robin arbitration between the flag-OFM and OFM word
// sources, announcing each block on the config port and streaming its words.
`timescale 1ns/1ps
module if_wr_sched #(
  parameter int         SPI_WIDTH = 32,
  parameter int         TX_WIDTH  = 20,
  parameter int         SIZE_FLG  = 64,
  parameter int         SIZE_OFM  = 512,
  parameter logic [3:0] CODE_FLG  = 4'd5,
  parameter logic [3:0] CODE_OFM  = 4'd6
) (
  input  logic                 clk_chip,
  input  logic                 reset_n_chip,
  input  logic                 flg_req,
  input  logic                 flg_vld,
  input  logic [SPI_WIDTH-1:0] flg_data,
  output logic                 flg_ack,
  input  logic                 ofm_req,
  input  logic                 ofm_vld,
  input  logic [SPI_WIDTH-1:0] ofm_data,
  output logic                 ofm_ack,
  input  logic                 config_ready,
  output logic                 config_paulse,
  output logic [3:0]           config_data,
  input  logic                 wr_ready,
  output logic                 wr_req,
  output logic [SPI_WIDTH-1:0] wr_data,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 done_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_XFER, S_DONE} state_e;

  localparam logic [TX_WIDTH-1:0] SZ_FLG = TX_WIDTH'(SIZE_FLG);
  localparam logic [TX_WIDTH-1:0] SZ_OFM = TX_WIDTH'(SIZE_OFM);

  state_e                state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic                  pri_ofm_q, pri_ofm_d;
  logic [TX_WIDTH-1:0]   size_q, size_d;
  logic [TX_WIDTH-1:0]   count_q, count_d;
  logic [3:0]            cdata_q, cdata_d;
  logic                  seen_low_q, seen_low_d;
  logic                  done_q, done_d;
  logic                  pick_ofm;
  logic                  own_vld;
  logic [SPI_WIDTH-1:0]  own_data;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    pri_ofm_d  = pri_ofm_q;
    size_d     = size_q;
    count_d    = count_q;
    cdata_d    = cdata_q;
    seen_low_d = seen_low_q;
    done_d     = 1'b0;
    pick_ofm   = 1'b0;

    own_vld  = grant_q[1] ? ofm_vld  : flg_vld;
    own_data = grant_q[1] ? ofm_data : flg_data;
    wr_req   = (state_q == S_XFER) && wr_ready && own_vld && (count_q < size_q);
    wr_data  = (state_q == S_XFER) ? own_data : '0;
    flg_ack  = wr_req && grant_q[0];
    ofm_ack  = wr_req && grant_q[1];

    // DONE may only exit once the write interface has gone busy at least once
    if (state_q != S_IDLE && !config_ready) seen_low_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (config_ready && (flg_req || ofm_req)) begin
          pick_ofm   = ofm_req && (!flg_req || pri_ofm_q);
          grant_d    = pick_ofm ? 2'b10 : 2'b01;
          pri_ofm_d  = !pick_ofm;
          size_d     = pick_ofm ? SZ_OFM : SZ_FLG;
          cdata_d    = pick_ofm ? CODE_OFM : CODE_FLG;
          seen_low_d = 1'b0;
          state_d    = S_CFG;
        end
      end
      S_CFG: begin
        count_d = '0;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (wr_req) begin
          count_d = count_q + 1'b1;
          if (count_q == size_q - 1'b1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (config_ready && seen_low_q) begin
          state_d = S_IDLE;
          grant_d = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_chip or negedge reset_n_chip) begin
    if (!reset_n_chip) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      pri_ofm_q  <= 1'b0;
      size_q     <= '0;
      count_q    <= '0;
      cdata_q    <= '0;
      seen_low_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      pri_ofm_q  <= pri_ofm_d;
      size_q     <= size_d;
      count_q    <= count_d;
      cdata_q    <= cdata_d;
      seen_low_q <= seen_low_d;
      done_q     <= done_d;
    end
  end

  assign config_paulse = (state_q == S_CFG);
  assign config_data   = cdata_q;
  assign grant         = grant_q;
  assign busy          = (state_q != S_IDLE);
  assign done_pulse    = done_q;

endmodule

// File: tb/tb_if_wr_sched.sv
// Self-checking bench for if_wr_sched: directed block sequences with random
// flow control, checked against a word-level round-robin/stream model.
`timescale 1ns/1ps
module tb_if_wr_sched;

  logic        clk_chip = 1'b0;
  logic        reset_n_chip;
  logic        flg_req, flg_vld, ofm_req, ofm_vld;
  logic [31:0] flg_data, ofm_data;
  logic        flg_ack, ofm_ack;
  logic        config_ready, config_paulse;
  logic [3:0]  config_data;
  logic        wr_ready, wr_req;
  logic [31:0] wr_data;
  logic [1:0]  grant;
  logic        busy, done_pulse;

  logic        s_flg_req, s_flg_vld, s_ofm_req, s_ofm_vld;
  logic        s_flg_ack, s_ofm_ack, s_cfg, s_wr_req, s_busy, s_done;
  logic [3:0]  s_cdata;
  logic [31:0] s_wr_data;
  logic [1:0]  s_grant;

  int          tests  = 0;
  int          failed = 0;
  bit          prio_ofm;
  logic [31:0] mem [512];

  always #5 clk_chip = ~clk_chip;

  if_wr_sched u_dut (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip),
    .flg_req(flg_req), .flg_vld(flg_vld), .flg_data(flg_data), .flg_ack(flg_ack),
    .ofm_req(ofm_req), .ofm_vld(ofm_vld), .ofm_data(ofm_data), .ofm_ack(ofm_ack),
    .config_ready(config_ready), .config_paulse(config_paulse), .config_data(config_data),
    .wr_ready(wr_ready), .wr_req(wr_req), .wr_data(wr_data),
    .grant(grant), .busy(busy), .done_pulse(done_pulse)
  );

  if_wr_sched #(.SIZE_FLG(1), .SIZE_OFM(3)) u_small (
    .clk_chip(clk_chip), .reset_n_chip(reset_n_chip),
    .flg_req(s_flg_req), .flg_vld(s_flg_vld), .flg_data(flg_data), .flg_ack(s_flg_ack),
    .ofm_req(s_ofm_req), .ofm_vld(s_ofm_vld), .ofm_data(ofm_data), .ofm_ack(s_ofm_ack),
    .config_ready(config_ready), .config_paulse(s_cfg), .config_data(s_cdata),
    .wr_ready(wr_ready), .wr_req(s_wr_req), .wr_data(s_wr_data),
    .grant(s_grant), .busy(s_busy), .done_pulse(s_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One block: model picks the owner, then every cycle the expected strobe is
  // derived from the flow-control inputs and the number of words still owed.
  task automatic do_block(input int n_abort, input int mode, input bit drop_req);
    bit          exp_ofm, found, v, e;
    int          n, sent;
    logic [3:0]  code;
    exp_ofm  = ofm_req && (!flg_req || prio_ofm);
    prio_ofm = !exp_ofm;
    n        = exp_ofm ? 512 : 64;
    code     = exp_ofm ? 4'd6 : 4'd5;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk_chip);
      config_ready = 1'b1; wr_ready = 1'b1; flg_vld = 1'b1; ofm_vld = 1'b1;
      #1;
      chk("wr_req_outside_xfer", wr_req, 1'b0);
      chk("done_while_waiting", done_pulse, 1'b0);
      if (config_paulse) found = 1'b1;
    end
    chk("cfg_pulse_seen", found, 1'b1);
    if (!found) return;
    chk("config_data", config_data, code);
    chk("grant", grant, exp_ofm ? 2'b10 : 2'b01);
    chk("busy_cfg", busy, 1'b1);
    sent = 0;
    for (int c = 0; c < 8000 && sent < n && sent != n_abort; c++) begin
      @(negedge clk_chip);
      config_ready = 1'b0;
      if (drop_req) begin flg_req = 1'b0; ofm_req = 1'b0; end
      case (mode)
        0:       begin wr_ready = 1'b1;          v = 1'b1;          end
        1:       begin wr_ready = (c % 2 == 0);  v = $urandom % 2;  end
        default: begin wr_ready = $urandom % 2;  v = $urandom % 2;  end
      endcase
      if (exp_ofm) begin
        ofm_vld = v; ofm_data = mem[sent]; flg_vld = $urandom % 2; flg_data = $urandom;
      end else begin
        flg_vld = v; flg_data = mem[sent]; ofm_vld = $urandom % 2; ofm_data = $urandom;
      end
      #1;
      e = wr_ready && v;
      chk("wr_req", wr_req, e);
      chk("owner_ack", exp_ofm ? ofm_ack : flg_ack, e);
      chk("other_ack", exp_ofm ? flg_ack : ofm_ack, 1'b0);
      if (e) begin
        chk("wr_data", wr_data, mem[sent]);
        sent++;
      end
    end
    if (n_abort >= 0 && sent == n_abort) return;
    chk("xfer_in_budget", sent, n);
    @(negedge clk_chip);
    wr_ready = 1'b1; flg_vld = 1'b1; ofm_vld = 1'b1;
    #1;
    chk("no_extra_word", wr_req, 1'b0);
    chk("busy_done", busy, 1'b1);
    chk("done_early", done_pulse, 1'b0);
    @(negedge clk_chip);
    config_ready = 1'b1;
    #1;
    chk("done_before_ready", done_pulse, 1'b0);
    @(negedge clk_chip);
    #1;
    chk("done_pulse", done_pulse, 1'b1);
    chk("busy_after", busy, 1'b0);
    chk("grant_cleared", grant, 2'b00);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    reset_n_chip = 1'b0;
    flg_req = 0; flg_vld = 0; ofm_req = 0; ofm_vld = 0;
    flg_data = '0; ofm_data = '0; config_ready = 0; wr_ready = 0;
    s_flg_req = 0; s_flg_vld = 0; s_ofm_req = 0; s_ofm_vld = 0;
    prio_ofm = 1'b0;
    repeat (2) @(negedge clk_chip);
    #1;
    chk("reset_outputs", {wr_req, flg_ack, ofm_ack, grant, busy, config_paulse,
                          config_data, done_pulse, wr_data}, '0);
    @(negedge clk_chip);
    reset_n_chip = 1'b1;

    // round-robin tie: flg, ofm, flg
    flg_req = 1'b1; ofm_req = 1'b1;
    do_block(-1, 0, 1'b0);
    do_block(-1, 0, 1'b0);
    do_block(-1, 2, 1'b1);

    // config_ready low keeps a pending request waiting in IDLE
    @(negedge clk_chip);
    config_ready = 1'b0; flg_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_chip);
      #1;
      chk("idle_no_cfg", config_paulse, 1'b0);
      chk("idle_not_busy", busy, 1'b0);
    end
    do_block(-1, 0, 1'b1);

    // OFM block with alternating wr_ready and random valid
    @(negedge clk_chip);
    ofm_req = 1'b1;
    do_block(-1, 1, 1'b1);

    // reset in the middle of an OFM block
    @(negedge clk_chip);
    ofm_req = 1'b1;
    do_block(10, 2, 1'b1);
    @(negedge clk_chip);
    reset_n_chip = 1'b0;
    #1;
    chk("abort_outputs", {wr_req, flg_ack, ofm_ack, grant, busy, config_paulse,
                          config_data, done_pulse, wr_data}, '0);
    prio_ofm = 1'b0;
    @(negedge clk_chip);
    #1;
    chk("abort_no_done", done_pulse, 1'b0);
    reset_n_chip = 1'b1;
    flg_req = 1'b1; ofm_req = 1'b1;
    do_block(-1, 0, 1'b1);

    // single-word flag blocks on the small instance, twice
    for (int r = 0; r < 2; r++) begin
      @(negedge clk_chip);
      s_flg_req = 1'b1; s_flg_vld = 1'b1; wr_ready = 1'b1; config_ready = 1'b1;
      #1;
      chk("s_idle", s_cfg, 1'b0);
      @(negedge clk_chip);
      flg_data = $urandom;
      #1;
      chk("s_cfg", s_cfg, 1'b1);
      chk("s_cdata", s_cdata, 4'd5);
      s_flg_req = 1'b0; config_ready = 1'b0;
      @(negedge clk_chip);
      #1;
      chk("s_wr_req", s_wr_req, 1'b1);
      chk("s_ack", s_flg_ack, 1'b1);
      chk("s_wr_data", s_wr_data, flg_data);
      @(negedge clk_chip);
      config_ready = 1'b1;
      #1;
      chk("s_single_word", s_wr_req, 1'b0);
      chk("s_busy_done", s_busy, 1'b1);
      @(negedge clk_chip);
      #1;
      chk("s_done", s_done, 1'b1);
      chk("s_idle_after", s_busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/if_wr_sched.md
IF_WR_SCHED -- requirements
Module: if_wr_sched

Interface
REQ-001 Parameter SPI_WIDTH, 32: word width of requester data and wr_data.
REQ-002 Parameter TX_WIDTH, 20: width of word counter and size parameters.
REQ-003 Parameter SIZE_FLG, 64: words per flag-OFM block.
REQ-004 Parameter SIZE_OFM, 512: words per OFM block.
REQ-005 Parameter CODE_FLG, 4'd5: config_data code for flag-OFM block.
REQ-006 Parameter CODE_OFM, 4'd6: config_data code for OFM block.
REQ-007 clk_chip  in  1  single clock; all logic is on its rising edge.
REQ-008 reset_n_chip  in  1  asynchronous, active-low reset.
REQ-009 flg_req  in  1  level: flag-OFM block pending; flg_vld  in  1  word valid; flg_data  in  SPI_WIDTH  word; flg_ack  out  1  word consumed.
REQ-010 ofm_req, ofm_vld, ofm_data, ofm_ack: same as REQ-009 for the OFM source.
REQ-011 config_ready  in  1  FIFO-write interface idle; config_paulse  out  1  one-cycle start pulse; config_data  out  4  block code.
REQ-012 wr_ready  in  1  FIFO-write interface accepts a word; wr_req  out  1  word write strobe; wr_data  out  SPI_WIDTH  word.
REQ-013 grant  out  2  one-hot owner {ofm,flg}; busy  out  1  state != IDLE; done_pulse  out  1  block finished.

Function
REQ-014 States: IDLE, CFG, XFER, DONE; encoding is free.
REQ-015 IDLE->CFG when config_ready=1 and (flg_req|ofm_req); grant and owner size/code latch on this edge.
REQ-016 Arbitration is round-robin: if both requests are high, the source not granted last wins; after reset, flg wins the first tie.
REQ-017 A single pending request is granted immediately regardless of the pointer.
REQ-018 The pointer updates only on a grant.
REQ-019 CFG lasts exactly one cycle, with config_paulse=1 and config_data=owner code; then CFG->XFER.
REQ-020 config_data holds its value until the next CFG.
REQ-021 In XFER: wr_req = wr_ready & owner_vld & (count < owner size), combinational.
REQ-022 In XFER: wr_data = owner data, combinational; owner ack = wr_req; non-owner ack = 0.
REQ-023 count is TX_WIDTH bits, clears in CFG, and increments on each wr_req.
REQ-024 XFER->DONE on the edge where wr_req=1 and count = size-1.
REQ-025 owner_vld=0 or wr_ready=0 stalls with no wr_req and count held; there is no timeout.
REQ-026 A requester dropping *_req mid-transfer has no effect; the block completes on *_vld.
REQ-027 DONE waits until config_ready=1 while config_ready was low at least one cycle since CFG.
REQ-028 On that DONE exit: done_pulse=1 for one cycle, grant cleared, state->IDLE.
REQ-029 A new grant may occur at the earliest on the cycle after done_pulse.
REQ-030 Outside XFER: wr_req=0, acks=0, wr_data=0.
REQ-031 wr_req never asserts in a cycle where wr_ready=0.

Reset
REQ-032 While reset_n_chip=0: state=IDLE, config_paulse=0, config_data=0, wr_req=0, acks=0, grant=0, busy=0, done_pulse=0, count=0, pointer=flg.
REQ-033 Reset asserted mid-XFER aborts the block immediately, with no done_pulse.
REQ-034 After reset release, the first action occurs no earlier than the first clk_chip edge with reset_n_chip=1.

Verification
REQ-035 flg_req=1, flg_vld=1, wr_ready=1, config_ready pulses low then high -> config_paulse with config_data=5, exactly 64 wr_req, done_pulse once, busy low after.
REQ-036 flg_req and ofm_req both high continuously -> grants alternate flg, ofm, flg; config_data sequence 5, 6, 5.
REQ-037 OFM block with wr_ready toggled 1/0 every cycle and ofm_vld random -> exactly 512 wr_req, each with wr_ready=1 and ofm_vld=1; data order preserved.
REQ-038 config_ready held low with flg_req=1 -> no config_paulse; stays IDLE until config_ready=1.
REQ-039 Reset asserted after 10 words of an OFM block -> all outputs zero next cycle, no done_pulse; next tie after release grants flg.
REQ-040 SIZE_FLG=1 -> single wr_req, then DONE; count wraps cleanly back to 0 at the next CFG.
